// File: rtl/retry_id_scheduler.sv
// ============================================================================
// Module   : retry_id_scheduler
// Purpose  : Transaction-ID allocator and new/retry issue arbiter with a
//            per-ID retry budget. Optional statistics: RETRY_ID_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retry_id_scheduler #(
    parameter int IDSize     = 4,
    parameter int MaxRetries = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              new_valid_i,
    output logic              new_ready_o,
    input  logic              retry_valid_i,
    input  logic [IDSize-1:0] retry_id_i,
    output logic              retry_ready_o,
    input  logic              done_valid_i,
    input  logic [IDSize-1:0] done_id_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output logic [IDSize-1:0] issue_id_o,
    output logic              issue_retry_o,
    output logic              abort_valid_o,
    output logic [IDSize-1:0] abort_id_o,
    output logic              spurious_o,
    output logic [15:0]       retry_total_o,
    output logic [15:0]       abort_total_o
);

    localparam int NUM_IDS = 1 << IDSize;
    localparam int CW      = $clog2(MaxRetries + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MaxRetries);

    logic [NUM_IDS-1:0] out_q, out_d;
    logic [CW-1:0]      cnt_q [NUM_IDS];
    logic [CW-1:0]      cnt_d [NUM_IDS];
    logic               issue_valid_q, issue_valid_d;
    logic [IDSize-1:0]  issue_id_q, issue_id_d;
    logic               issue_retry_q, issue_retry_d;
    logic               abort_valid_q, abort_valid_d;
    logic [IDSize-1:0]  abort_id_q, abort_id_d;
    logic               spurious_q, spurious_d;

    logic               load_en;
    logic               any_free;
    logic               alloc_found;
    logic [IDSize-1:0]  alloc_id;
    logic               retry_accept;
    logic               new_grant;
    logic               retry_inc;
    logic               abort_inc;

    assign load_en       = !issue_valid_q || issue_ready_i;
    assign any_free      = ~&out_q;
    // Handshakes are held low during reset so no input is seen as accepted.
    assign retry_ready_o = load_en && !rst_i;
    assign new_ready_o   = load_en && !rst_i && !retry_valid_i && any_free;
    assign retry_accept  = retry_valid_i && retry_ready_o;
    assign new_grant     = new_valid_i && new_ready_o;

    always_comb begin
        alloc_id    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (!alloc_found && !out_q[i]) begin
                alloc_id    = IDSize'(i);
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        out_d         = out_q;
        cnt_d         = cnt_q;
        issue_valid_d = issue_valid_q;
        issue_id_d    = issue_id_q;
        issue_retry_d = issue_retry_q;
        abort_valid_d = 1'b0;
        abort_id_d    = '0;
        spurious_d    = 1'b0;
        retry_inc     = 1'b0;
        abort_inc     = 1'b0;

        if (load_en) begin
            issue_valid_d = 1'b0;
        end

        if (retry_accept) begin
            // A retry racing a done for the same ID loses: the ID is being released.
            if (!out_q[retry_id_i] || (done_valid_i && (done_id_i == retry_id_i))) begin
                spurious_d = 1'b1;
            end else if (cnt_q[retry_id_i] == MAX_CNT) begin
                out_d[retry_id_i] = 1'b0;
                abort_valid_d     = 1'b1;
                abort_id_d        = retry_id_i;
                abort_inc         = 1'b1;
            end else begin
                cnt_d[retry_id_i] = cnt_q[retry_id_i] + CW'(1);
                issue_valid_d     = 1'b1;
                issue_id_d        = retry_id_i;
                issue_retry_d     = 1'b1;
                retry_inc         = 1'b1;
            end
        end else if (new_grant) begin
            out_d[alloc_id] = 1'b1;
            cnt_d[alloc_id] = '0;
            issue_valid_d   = 1'b1;
            issue_id_d      = alloc_id;
            issue_retry_d   = 1'b0;
        end

        if (done_valid_i) begin
            if (out_q[done_id_i]) begin
                out_d[done_id_i] = 1'b0;
            end else begin
                spurious_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_id_q    <= '0;
            issue_retry_q <= 1'b0;
            abort_valid_q <= 1'b0;
            abort_id_q    <= '0;
            spurious_q    <= 1'b0;
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q         <= out_d;
            cnt_q         <= cnt_d;
            issue_valid_q <= issue_valid_d;
            issue_id_q    <= issue_id_d;
            issue_retry_q <= issue_retry_d;
            abort_valid_q <= abort_valid_d;
            abort_id_q    <= abort_id_d;
            spurious_q    <= spurious_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_id_o    = issue_id_q;
    assign issue_retry_o = issue_retry_q;
    assign abort_valid_o = abort_valid_q;
    assign abort_id_o    = abort_id_q;
    assign spurious_o    = spurious_q;

`ifdef RETRY_ID_SCHED_STATS_EN
    logic [15:0] retry_total_q;
    logic [15:0] abort_total_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_total_q <= '0;
            abort_total_q <= '0;
        end else begin
            if (retry_inc && (retry_total_q != 16'hFFFF)) begin
                retry_total_q <= retry_total_q + 16'd1;
            end
            if (abort_inc && (abort_total_q != 16'hFFFF)) begin
                abort_total_q <= abort_total_q + 16'd1;
            end
        end
    end

    assign retry_total_o = retry_total_q;
    assign abort_total_o = abort_total_q;
`else
    logic stats_unused;
    assign stats_unused  = retry_inc ^ abort_inc;
    assign retry_total_o = 16'd0;
    assign abort_total_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: doc/retry_id_scheduler.md
# retry_id_scheduler

Sequencing controller for the retry datapath. It hands out transaction IDs to new operations, arbitrates between fresh issues and retry requests coming back from the retry end stage, tracks outstanding IDs, and aborts IDs that exceed a retry budget. It sits in front of the retry start / time-redundant pipeline and drives the ID and retry-flag sideband that the pipeline carries alongside the data.

## Interface
- `IDSize`, default 4: ID width; the block manages 2**IDSize IDs.
- `MaxRetries`, default 3: maximum reissues per ID before it is aborted; must be ≥1.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `new_valid_i` in 1: a new operation requests an ID.
- `new_ready_o` out 1: an ID is granted to the new operation this cycle.
- `retry_valid_i` in 1: retry request from the retry end stage.
- `retry_id_i` in IDSize: ID to retry.
- `retry_ready_o` out 1: retry request accepted.
- `done_valid_i` in 1: the ID completed successfully and is released.
- `done_id_i` in IDSize: completed ID.
- `issue_valid_o` out 1: issue register holds a valid entry.
- `issue_ready_i` in 1: downstream accepts the issue.
- `issue_id_o` out IDSize: issued ID.
- `issue_retry_o` out 1: the issue is a reissue, not a new operation.
- `abort_valid_o` out 1: one-cycle pulse; an ID was aborted.
- `abort_id_o` out IDSize: aborted ID; valid while `abort_valid_o` is high.
- `spurious_o` out 1: one-cycle pulse; a retry or done named an ID that was not outstanding.
- `retry_total_o` out 16: saturating count of reissues (see Configuration).
- `abort_total_o` out 16: saturating count of aborts (see Configuration).

## Operation
- State:
  - Registered outstanding bit vector `out_q[2**IDSize]`.
  - Per-ID retry counter, `$clog2(MaxRetries+1)` bits.
  - One-entry issue register holding id, retry flag and valid.
- Load enable: `L = !issue_valid_o || issue_ready_i`.
- Priority: retry beats new. `retry_ready_o = L`.
- New grant: `new_ready_o = L && !retry_valid_i && (any bit of out_q clear)`.
- Allocation:
  - Lowest-index ID with `out_q` clear, computed from the registered `out_q` only.
  - On a grant: set `out_q[id]`, clear that ID's counter, load the issue register with the ID and `issue_retry_o=0`.
- Accepted retry, resolved in priority order:
  - If `out_q[id]` is clear, or `done_valid_i && done_id_i==retry_id_i` in the same cycle: drop the retry and pulse `spurious_o`.
  - Else if the counter equals `MaxRetries`: clear `out_q[id]`, pulse `abort_valid_o` with `abort_id_o=id`, load nothing into the issue register.
  - Else: increment the counter and load the issue register with the ID and `issue_retry_o=1`.
- Done:
  - If `out_q[done_id_i]` is set: clear it.
  - Otherwise pulse `spurious_o` and change no state.
  - A released ID becomes allocatable the following cycle.
- If nothing is loaded while `L` is high, the issue register goes invalid.

## Timing
- Grant or accepted retry at cycle N: `issue_valid_o` is high at N+1. Latency 1 cycle.
- Full throughput: one issue per cycle while `issue_ready_i` stays high.
- Stall: while `issue_valid_o && !issue_ready_i`, the issue register holds id and flag stable, and both `new_ready_o` and `retry_ready_o` are low.
- `abort_valid_o`, `abort_id_o` and `spurious_o` are registered and assert in cycle N+1 for an event in cycle N.
- Full: all IDs outstanding gives `new_ready_o=0`. A done at cycle N allows a grant at N+1 at the earliest.
- No wrap-around on counters: the per-ID counter never exceeds `MaxRetries`; the 16-bit totals saturate at 0xFFFF.
- Reset (synchronous, with `rst_i` high at a clock edge):
  - All outputs 0 and `out_q` all clear.
  - All per-ID counters and totals 0.
  - The issue register is invalidated even in the middle of a stall.
  - Inputs are ignored while `rst_i` is high.

## Configuration
- Macro `RETRY_ID_SCHED_STATS_EN`.
- Defined: `retry_total_o` increments on every reissue and `abort_total_o` on every abort, both saturating at 0xFFFF and cleared by reset.
- Undefined: both ports are tied to 0 and the counters are not instantiated. All other behaviour is identical.

## Test plan
All scenarios use IDSize=2 and MaxRetries=2.
- **Allocation and full:** hold `new_valid_i=1` with `issue_ready_i=1`, no done. Expect IDs 0,1,2,3 issued with `issue_retry_o=0`; then `new_ready_o=0`. Send done id 1 and expect the next grant to be ID 1 one cycle later.
- **Retry priority:** assert `retry_valid_i` (id 2) and `new_valid_i` together. Expect ID 2 issued with `issue_retry_o=1`, `new_ready_o=0` that cycle, and the new operation granted the next cycle.
- **Abort:** retry id 0 three times. Expect two reissues, then `abort_valid_o=1` with `abort_id_o=0`, ID 0 free again, and `abort_total_o=1` when the macro is defined.
- **Spurious:** retry id 3 while it is not outstanding. Expect `spurious_o` pulse, no issue. A done on a free ID also pulses `spurious_o`.
- **Same-cycle conflict:** done id 1 and retry id 1 in the same cycle. Expect ID 1 freed, `spurious_o=1`, no reissue.
- **Stall and reset:** hold `issue_ready_i=0` for 5 cycles. Expect `issue_id_o` stable and both ready outputs 0. Pulse `rst_i` mid-stall and expect `issue_valid_o=0` and all IDs free on the next cycle.
